// File: rtl/latency_meter_mc.sv
// Multi-channel interrupt latency meter: raises per-channel IRQs round-robin,
// times irq->ack and ack->SPI start, and streams a result frame per channel.

module latency_meter_deb #(
    parameter int   DEB_LEN = 10,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    logic [DEB_LEN-1:0] pipe;

    // Output only moves once the older pipe bits agree; mixed history holds it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= {DEB_LEN{RST_VAL}};
            deb  <= RST_VAL;
        end else begin
            pipe <= {pipe[DEB_LEN-2:0], raw};
            if (&pipe[DEB_LEN-1:1]) begin
                deb <= 1'b1;
            end else if (~|pipe[DEB_LEN-1:1]) begin
                deb <= 1'b0;
            end
        end
    end

endmodule

module latency_meter_mc #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 32,
    parameter int PERIOD  = 500000,
    parameter int DEB_LEN = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sck,
    input  logic            ssel,
    input  logic [N_CH-1:0] int_ack,
    input  logic            byte_done,
    input  logic            clr_max,
    output logic [N_CH-1:0] irq,
    output logic [7:0]      tx_byte,
    output logic [3:0]      cur_ch,
    output logic [2:0]      state_o,
    output logic            sat
);

    localparam int NB    = CNT_W / 8;
    localparam int FLEN  = 1 + 3 * NB;
    localparam int IDX_W = 5;
    localparam int PER_W = $clog2(PERIOD + 1);

    typedef enum logic [2:0] {
        ARM  = 3'd0,
        IDLE = 3'd1,
        ACK  = 3'd2,
        SPIW = 3'd3,
        SEND = 3'd4
    } state_t;

    state_t              state;
    state_t              state_n;
    logic                sck_deb;
    logic                ssel_deb;
    logic [N_CH-1:0]     ack_deb;
    logic [PER_W-1:0]    period_cnt;
    logic [CNT_W-1:0]    ack_lat;
    logic [CNT_W-1:0]    spi_lat;
    logic [CNT_W-1:0]    max_r [N_CH];
    logic [IDX_W-1:0]    idx;
    logic                ack_cur;
    logic                spi_go;
    logic                period_hit;
    logic                frame_end;
    logic [CNT_W-1:0]    max_cur;
    logic [N_CH-1:0]     irq_set;
    logic [8*FLEN-1:0]   frame;
    logic [7:0]          tx_next;

    latency_meter_deb #(.DEB_LEN(DEB_LEN), .RST_VAL(1'b0)) u_deb_sck (
        .clk (clk),
        .rst (rst),
        .raw (sck),
        .deb (sck_deb)
    );

    latency_meter_deb #(.DEB_LEN(DEB_LEN), .RST_VAL(1'b1)) u_deb_ssel (
        .clk (clk),
        .rst (rst),
        .raw (ssel),
        .deb (ssel_deb)
    );

    for (genvar g = 0; g < N_CH; g++) begin : g_ack
        latency_meter_deb #(.DEB_LEN(DEB_LEN), .RST_VAL(1'b1)) u_deb_ack (
            .clk (clk),
            .rst (rst),
            .raw (int_ack[g]),
            .deb (ack_deb[g])
        );
    end

    // Per-channel selections are decoded by comparison so cur_ch never indexes past N_CH.
    always_comb begin
        ack_cur = 1'b0;
        max_cur = '0;
        irq_set = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cur_ch == 4'(k)) begin
                ack_cur    = ack_deb[k];
                max_cur    = max_r[k];
                irq_set[k] = 1'b1;
            end
        end
    end

    assign spi_go     = ~ssel_deb & sck_deb;
    assign period_hit = (period_cnt >= PER_W'(PERIOD));
    assign frame_end  = (idx >= IDX_W'(FLEN + 1));
    assign frame      = {max_cur, spi_lat, ack_lat, 4'hA, cur_ch};
    assign state_o    = state;

    always_comb begin
        tx_next = 8'h00;
        for (int k = 0; k < FLEN; k++) begin
            if (idx == IDX_W'(k)) begin
                tx_next = frame[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARM;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ARM:     if (byte_done)  state_n = IDLE;
            IDLE:    if (period_hit) state_n = ACK;
            ACK:     if (ack_cur)    state_n = SPIW;
            SPIW:    if (spi_go)     state_n = SEND;
            SEND:    if (frame_end)  state_n = IDLE;
            default:                 state_n = ARM;
        endcase
    end

    // ack_lat is corrected on exit so the reported value excludes most of the debounce lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt <= '0;
            ack_lat    <= '0;
            spi_lat    <= '0;
            idx        <= '0;
            irq        <= '0;
            tx_byte    <= 8'h00;
            cur_ch     <= 4'd0;
            sat        <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                max_r[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (period_hit) begin
                        irq        <= irq_set;
                        ack_lat    <= '0;
                        period_cnt <= '0;
                    end else if (!ack_cur) begin
                        period_cnt <= period_cnt + PER_W'(1);
                    end
                end
                ACK: begin
                    if (ack_cur) begin
                        ack_lat <= (ack_lat > CNT_W'(DEB_LEN - 1)) ?
                                   ack_lat - CNT_W'(DEB_LEN - 1) : '0;
                        spi_lat <= '0;
                        irq     <= '0;
                    end else if (!(&ack_lat)) begin
                        ack_lat <= ack_lat + CNT_W'(1);
                    end
                end
                SPIW: begin
                    if (spi_go) begin
                        tx_byte <= frame[7:0];
                        idx     <= IDX_W'(1);
                        for (int k = 0; k < N_CH; k++) begin
                            if (cur_ch == 4'(k) && ack_lat > max_r[k]) begin
                                max_r[k] <= ack_lat;
                            end
                        end
                    end else if (!(&spi_lat)) begin
                        spi_lat <= spi_lat + CNT_W'(1);
                    end
                end
                SEND: begin
                    if (frame_end) begin
                        idx    <= '0;
                        cur_ch <= (cur_ch == 4'(N_CH - 1)) ? 4'd0 : cur_ch + 4'd1;
                    end else if (byte_done) begin
                        tx_byte <= tx_next;
                        idx     <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase

            if ((state == ACK && &ack_lat) || (state == SPIW && &spi_lat)) begin
                sat <= 1'b1;
            end

            if (clr_max) begin
                for (int k = 0; k < N_CH; k++) begin
                    max_r[k] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_latency_meter_mc.sv
// Self-checking bench: a 4-channel 32-bit meter and a 2-channel 8-bit meter,
// each compared against an arithmetic timing/frame model.

module tb_latency_meter_mc;

    localparam int PERIOD_T = 100;
    localparam int DEB      = 10;
    // Raw input edge to FSM reaction: debounce pipe plus the output register.
    localparam int LAG      = DEB + 1;
    localparam int NCH_A    = 4;
    localparam int W_A      = 32;
    localparam int NCH_B    = 2;
    localparam int W_B      = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       sck_v  = 2'b00;
    logic [1:0]       ssel_v = 2'b11;
    logic [1:0]       bd_v   = 2'b00;
    logic [1:0]       clr_v  = 2'b00;
    logic [NCH_A-1:0] ack_a  = '0;
    logic [NCH_B-1:0] ack_b  = '0;
    logic [NCH_A-1:0] irq_a;
    logic [NCH_B-1:0] irq_b;
    logic [7:0]       tx_a, tx_b;
    logic [3:0]       ch_a, ch_b;
    logic [2:0]       st_a, st_b;
    logic             sat_a, sat_b;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     exp_ch [2];
    longint maxv [2][4];
    bit     exp_sat [2];

    always #5 clk = ~clk;

    latency_meter_mc #(.N_CH(NCH_A), .CNT_W(W_A), .PERIOD(PERIOD_T), .DEB_LEN(DEB)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck_v[0]),
        .ssel      (ssel_v[0]),
        .int_ack   (ack_a),
        .byte_done (bd_v[0]),
        .clr_max   (clr_v[0]),
        .irq       (irq_a),
        .tx_byte   (tx_a),
        .cur_ch    (ch_a),
        .state_o   (st_a),
        .sat       (sat_a)
    );

    latency_meter_mc #(.N_CH(NCH_B), .CNT_W(W_B), .PERIOD(PERIOD_T), .DEB_LEN(DEB)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck_v[1]),
        .ssel      (ssel_v[1]),
        .int_ack   (ack_b),
        .byte_done (bd_v[1]),
        .clr_max   (clr_v[1]),
        .irq       (irq_b),
        .tx_byte   (tx_b),
        .cur_ch    (ch_b),
        .state_o   (st_b),
        .sat       (sat_b)
    );

    function automatic int nch(input int u);
        return (u == 0) ? NCH_A : NCH_B;
    endfunction

    function automatic int cw(input int u);
        return (u == 0) ? W_A : W_B;
    endfunction

    function automatic logic [15:0] irq_of(input int u);
        return (u == 0) ? 16'(irq_a) : 16'(irq_b);
    endfunction

    function automatic logic [7:0] tx_of(input int u);
        return (u == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic [3:0] ch_of(input int u);
        return (u == 0) ? ch_a : ch_b;
    endfunction

    function automatic logic [2:0] st_of(input int u);
        return (u == 0) ? st_a : st_b;
    endfunction

    function automatic logic sat_of(input int u);
        return (u == 0) ? sat_a : sat_b;
    endfunction

    function automatic longint all1(input int u);
        return (longint'(1) << cw(u)) - 1;
    endfunction

    // Counter runs from irq until the FSM sees the debounced ack, then drops DEB-1.
    function automatic longint exp_ack(input int u, input int d);
        longint raw;
        raw = d + LAG;
        if (raw > all1(u)) raw = all1(u);
        raw = raw - (DEB - 1);
        if (raw < 0) raw = 0;
        return raw;
    endfunction

    function automatic longint exp_spi(input int u, input int s);
        longint raw;
        raw = s - 1;
        if (raw > all1(u)) raw = all1(u);
        return raw;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ack(input int u, input int ch, input logic v);
        if (u == 0) ack_a = v ? (ack_a | (4'b0001 << ch)) : (ack_a & ~(4'b0001 << ch));
        else        ack_b = v ? (ack_b | (2'b01 << ch))   : (ack_b & ~(2'b01 << ch));
    endtask

    task automatic pulse_bd(input int u);
        bd_v[u[0]] = 1'b1;
        step(1);
        bd_v[u[0]] = 1'b0;
    endtask

    task automatic idle_inputs();
        sck_v  = 2'b00;
        ssel_v = 2'b11;
        bd_v   = 2'b00;
        clr_v  = 2'b00;
        ack_a  = '0;
        ack_b  = '0;
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            exp_ch[u]  = 0;
            exp_sat[u] = 1'b0;
            for (int k = 0; k < 4; k++) maxv[u][k] = 0;
        end
    endtask

    // One measurement on unit u: wait irq, hold ack d cycles, SPI start s cycles later, read n_done bytes.
    task automatic run_round(input int u, input int d, input int s, input int n_done, input string tag);
        int          ch, other, nb, flen, waited;
        longint      a_e, s_e;
        logic [7:0]  fr [0:15];
        logic [15:0] irq_e;
        ch    = exp_ch[u];
        other = (ch + 1) % nch(u);
        nb    = cw(u) / 8;
        flen  = 1 + 3 * nb;
        irq_e = 16'd1 << ch;
        waited = 0;
        while (irq_of(u) == 16'd0 && waited < PERIOD_T + 4 * LAG + 20) begin
            step(1);
            waited++;
        end
        n_cmp++;
        if (irq_of(u) !== irq_e) begin
            n_bad++;
            $display("[TB] FAIL %s irq_raise: got %h want %h", tag, irq_of(u), irq_e);
            return;
        end
        set_ack(u, other, 1'b1);
        pulse_bd(u);
        step(d - 1);
        n_cmp++;
        if (st_of(u) !== 3'd2 || irq_of(u) !== irq_e || tx_of(u) !== 8'h00) begin
            n_bad++;
            $display("[TB] FAIL %s ack_wait: state %0d irq %h tx %h want state 2 irq %h tx 00",
                     tag, st_of(u), irq_of(u), tx_of(u), irq_e);
        end
        set_ack(u, ch, 1'b1);
        set_ack(u, other, 1'b0);
        step(s);
        ssel_v[u[0]] = 1'b0;
        sck_v[u[0]]  = 1'b1;
        step(LAG + 3);
        n_cmp++;
        if (st_of(u) !== 3'd4 || irq_of(u) !== 16'd0) begin
            n_bad++;
            $display("[TB] FAIL %s send_entry: state %0d irq %h want state 4 irq 0000",
                     tag, st_of(u), irq_of(u));
        end
        a_e = exp_ack(u, d);
        s_e = exp_spi(u, s);
        if (a_e > maxv[u][ch]) maxv[u][ch] = a_e;
        if (d + LAG >= all1(u) || s - 1 >= all1(u)) exp_sat[u] = 1'b1;
        fr[0] = 8'hA0 | 8'(ch);
        for (int k = 0; k < nb; k++) begin
            fr[1 + k]          = 8'(a_e >> (8 * k));
            fr[1 + nb + k]     = 8'(s_e >> (8 * k));
            fr[1 + 2 * nb + k] = 8'(maxv[u][ch] >> (8 * k));
        end
        for (int k = 0; k < n_done; k++) begin
            n_cmp++;
            if (tx_of(u) !== fr[k]) begin
                n_bad++;
                $display("[TB] FAIL %s byte%0d: got %h want %h", tag, k, tx_of(u), fr[k]);
            end
            pulse_bd(u);
        end
        if (n_done < flen) return;
        n_cmp++;
        if (tx_of(u) !== 8'h00) begin
            n_bad++;
            $display("[TB] FAIL %s tx_past_end: got %h want 00", tag, tx_of(u));
        end
        step(1);
        exp_ch[u] = (ch + 1) % nch(u);
        n_cmp++;
        if (st_of(u) !== 3'd1 || ch_of(u) !== 4'(exp_ch[u])) begin
            n_bad++;
            $display("[TB] FAIL %s next_ch: state %0d ch %0d want state 1 ch %0d",
                     tag, st_of(u), ch_of(u), exp_ch[u]);
        end
        n_cmp++;
        if (sat_of(u) !== exp_sat[u]) begin
            n_bad++;
            $display("[TB] FAIL %s sat: got %b want %b", tag, sat_of(u), exp_sat[u]);
        end
        ssel_v[u[0]] = 1'b1;
        sck_v[u[0]]  = 1'b0;
        set_ack(u, ch, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        step(3);
        rst = 1'b0;
        step(1);
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if ({irq_of(u), tx_of(u), ch_of(u), st_of(u), sat_of(u)} !== 32'd0) begin
                n_bad++;
                $display("[TB] FAIL reset_u%0d: irq %h tx %h ch %0d state %0d sat %b want all zero",
                         u, irq_of(u), tx_of(u), ch_of(u), st_of(u), sat_of(u));
            end
        end
    endtask

    task automatic test_arm_period();
        int n;
        step(2 * LAG);
        pulse_bd(0);
        n_cmp++;
        if (st_a !== 3'd1 || ch_a !== 4'd0) begin
            n_bad++;
            $display("[TB] FAIL arm_to_idle: state %0d ch %0d want state 1 ch 0", st_a, ch_a);
        end
        n = 0;
        while (irq_a == '0 && n < PERIOD_T + 50) begin
            step(1);
            n++;
        end
        n_cmp++;
        if (n != PERIOD_T + 1) begin
            n_bad++;
            $display("[TB] FAIL irq_period: irq after %0d cycles want %0d", n, PERIOD_T + 1);
        end
    endtask

    task automatic test_first_measure();
        run_round(0, 1000, 500, 1 + 3 * (W_A / 8), "first");
    endtask

    task automatic test_rounds();
        int d, s;
        for (int r = 0; r < 7; r++) begin
            if (r == 3) begin
                clr_v[0] = 1'b1;
                step(1);
                clr_v[0] = 1'b0;
                for (int k = 0; k < 4; k++) maxv[0][k] = 0;
            end
            d = $urandom_range(450, 50);
            s = $urandom_range(200, 20);
            run_round(0, d, s, 1 + 3 * (W_A / 8), $sformatf("round%0d", r));
        end
    endtask

    task automatic test_reset_mid_send();
        run_round(0, $urandom_range(300, 60), $urandom_range(120, 20), 3, "midsend");
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (irq_a !== '0 || tx_a !== 8'h00 || st_a !== 3'd0) begin
            n_bad++;
            $display("[TB] FAIL midsend_rst: irq %h tx %h state %0d want 0 00 0", irq_a, tx_a, st_a);
        end
        step(2);
        idle_inputs();
        model_reset();
        rst = 1'b0;
        step(2 * LAG);
        pulse_bd(0);
        n_cmp++;
        if (st_a !== 3'd1 || ch_a !== 4'd0) begin
            n_bad++;
            $display("[TB] FAIL rearm: state %0d ch %0d want state 1 ch 0", st_a, ch_a);
        end
    endtask

    task automatic test_irq_async();
        int n;
        n = 0;
        while (irq_a == '0 && n < PERIOD_T + 50) begin
            step(1);
            n++;
        end
        n_cmp++;
        if (irq_a !== 4'b0001) begin
            n_bad++;
            $display("[TB] FAIL irq_rearm: got %h want 1", irq_a);
        end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (irq_a !== '0) begin
            n_bad++;
            $display("[TB] FAIL irq_async_drop: got %h want 0", irq_a);
        end
        step(2);
        idle_inputs();
        model_reset();
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_saturation();
        step(2 * LAG);
        pulse_bd(1);
        n_cmp++;
        if (st_b !== 3'd1) begin
            n_bad++;
            $display("[TB] FAIL arm_b: state %0d want 1", st_b);
        end
        run_round(1, 400, 30, 1 + 3 * (W_B / 8), "sat8");
        run_round(1, 60, 40, 1 + 3 * (W_B / 8), "sat8b");
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        model_reset();
        step(1);
        n_cmp++;
        if (sat_b !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL sat_cleared: got %b want 0", sat_b);
        end
    endtask

    initial begin
        test_reset();
        test_arm_period();
        test_first_measure();
        test_rounds();
        test_reset_mid_send();
        test_irq_async();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: run exceeded time limit, %0d compared", n_cmp);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
